writeback_arbiter: RTL and testbench

- Producer side of the register file write port.
- Accepts results from two execution sources, the ALU (single-cycle) and the LSU (multi-cycle loads), each through its own valid/ready handshake.
- Arbitrates them onto the single registered write port (wr_en/wr_addr/wr_data).
- Keeps a per-register pending scoreboard so the issue stage can detect read-after-write hazards on registers with outstanding writes.

---
 rtl/rf_pkg.sv | 18 +
 rtl/writeback_arbiter_if.sv | 30 +++
 rtl/wb_hold_slot.sv | 45 ++++
 rtl/writeback_arbiter.sv | 94 +++++++++
 tb/tb_writeback_arbiter.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/rf_pkg.sv
// Shared constants and types for the register-file writeback path.
// wb_src_e order is the arbitration priority: lower value wins.
package rf_pkg;
    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = $clog2(NREGS);
    localparam int NSRC  = 2;

    typedef struct packed {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } wb_entry_t;

    typedef enum logic {
        WB_SRC_LSU = 1'b0,
        WB_SRC_ALU = 1'b1
    } wb_src_e;
endpackage

// File: rtl/writeback_arbiter_if.sv
// Bundle of the arbiter's source handshakes, scoreboard alloc and register-file write port.
interface writeback_arbiter_if;
    import rf_pkg::*;

    logic            alloc_en;
    logic [AW-1:0]   alloc_rd;
    logic            alloc_err;
    logic            alu_valid;
    logic            alu_ready;
    logic [AW-1:0]   alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            lsu_valid;
    logic            lsu_ready;
    logic [AW-1:0]   lsu_rd;
    logic [XLEN-1:0] lsu_data;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [XLEN-1:0] wr_data;
    logic [NREGS-1:0] pending;

    modport slave (
        input  alloc_en, alloc_rd, alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
        output alloc_err, alu_ready, lsu_ready, wr_en, wr_addr, wr_data, pending
    );

    modport master (
        output alloc_en, alloc_rd, alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
        input  alloc_err, alu_ready, lsu_ready, wr_en, wr_addr, wr_data, pending
    );
endinterface

// File: rtl/wb_hold_slot.sv
// One-entry holding register for a single result source.
// Ready depends only on held state and grant, so valid never loops back into ready.
module wb_hold_slot
    import rf_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      valid,
    output logic      ready,
    input  wb_entry_t in_entry,
    input  logic      grant,
    output logic      occupied,
    output wb_entry_t entry
);
    logic      hold_v_q, hold_v_d;
    wb_entry_t hold_q, hold_d;
    logic      take;

    assign ready    = !reset && (!hold_v_q || grant);
    assign take     = valid && ready;
    assign occupied = hold_v_q;
    assign entry    = hold_q;

    always_comb begin
        hold_v_d = hold_v_q;
        hold_d   = hold_q;
        if (grant)
            hold_v_d = 1'b0;
        // x0 results complete the handshake but are dropped here
        if (take && (in_entry.rd != '0)) begin
            hold_v_d = 1'b1;
            hold_d   = in_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_v_q <= 1'b0;
            hold_q   <= '0;
        end else begin
            hold_v_q <= hold_v_d;
            hold_q   <= hold_d;
        end
    end
endmodule

// File: rtl/writeback_arbiter.sv
// Fixed-priority arbiter of ALU/LSU results onto the registered register-file
// write port, with a per-register pending-write scoreboard.
module writeback_arbiter
    import rf_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    writeback_arbiter_if.slave  wb
);
    logic [NSRC-1:0] src_valid, src_ready, src_occ, src_grant;
    wb_entry_t       src_in  [NSRC];
    wb_entry_t       src_ent [NSRC];

    assign src_valid[WB_SRC_LSU] = wb.lsu_valid;
    assign src_valid[WB_SRC_ALU] = wb.alu_valid;
    assign src_in[WB_SRC_LSU]    = '{rd: wb.lsu_rd, data: wb.lsu_data};
    assign src_in[WB_SRC_ALU]    = '{rd: wb.alu_rd, data: wb.alu_data};
    assign wb.lsu_ready          = src_ready[WB_SRC_LSU];
    assign wb.alu_ready          = src_ready[WB_SRC_ALU];

    for (genvar s = 0; s < NSRC; s++) begin : g_slot
        wb_hold_slot u_slot (
            .clk      (clk),
            .reset    (reset),
            .valid    (src_valid[s]),
            .ready    (src_ready[s]),
            .in_entry (src_in[s]),
            .grant    (src_grant[s]),
            .occupied (src_occ[s]),
            .entry    (src_ent[s])
        );
    end

    logic      win_any;
    wb_entry_t win_entry;

    // Lowest wb_src_e index among occupied slots wins
    always_comb begin
        src_grant = '0;
        win_any   = 1'b0;
        win_entry = '0;
        for (int s = 0; s < NSRC; s++) begin
            if (src_occ[s] && !win_any) begin
                src_grant[s] = 1'b1;
                win_any      = 1'b1;
                win_entry    = src_ent[s];
            end
        end
    end

    logic             wr_en_q, wr_en_d;
    logic [AW-1:0]    wr_addr_q, wr_addr_d;
    logic [XLEN-1:0]  wr_data_q, wr_data_d;
    logic [NREGS-1:0] pending_q, pending_d;
    logic             alloc_err_q, alloc_err_d;
    logic [NREGS-1:0] set_vec, clr_vec;
    logic             alloc_live;

    assign alloc_live = wb.alloc_en && (wb.alloc_rd != '0);

    always_comb begin
        wr_en_d   = win_any;
        wr_addr_d = win_any ? win_entry.rd   : wr_addr_q;
        wr_data_d = win_any ? win_entry.data : wr_data_q;

        set_vec = alloc_live ? (NREGS'(1) << wb.alloc_rd) : '0;
        clr_vec = win_any    ? (NREGS'(1) << win_entry.rd) : '0;
        // set applied after clear so a coincident alloc keeps the bit
        pending_d    = ((pending_q & ~clr_vec) | set_vec) & ~NREGS'(1);
        alloc_err_d  = alloc_live && pending_q[wb.alloc_rd];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            pending_q   <= '0;
            alloc_err_q <= 1'b0;
        end else begin
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            pending_q   <= pending_d;
            alloc_err_q <= alloc_err_d;
        end
    end

    assign wb.wr_en     = wr_en_q;
    assign wb.wr_addr   = wr_addr_q;
    assign wb.wr_data   = wr_data_q;
    assign wb.pending   = pending_q;
    assign wb.alloc_err = alloc_err_q;
endmodule

// File: tb/tb_writeback_arbiter.sv
// Randomized and directed bench for writeback_arbiter against a queue-based reference model.
module tb_writeback_arbiter;
    import rf_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    writeback_arbiter_if wb();
    writeback_arbiter dut (.clk(clk), .reset(reset), .wb(wb));

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Reference model: each source holds at most one result; LSU always writes first.
    wb_entry_t        m_alu[$];
    wb_entry_t        m_lsu[$];
    bit [NREGS-1:0]   m_pend = '0;
    bit               m_wr_en = 1'b0;
    bit [AW-1:0]      m_wr_addr = '0;
    bit [XLEN-1:0]    m_wr_data = '0;
    bit               m_err = 1'b0;

    function automatic bit m_lsu_rdy();
        return !reset;
    endfunction

    function automatic bit m_alu_rdy();
        return !reset && (m_alu.size() == 0 || m_lsu.size() == 0);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit ra, rl;
        wb_entry_t w;
        bit have_w;
        ra = m_alu_rdy();
        rl = m_lsu_rdy();
        if (reset) begin
            m_alu.delete(); m_lsu.delete();
            m_pend = '0; m_wr_en = 0; m_wr_addr = '0; m_wr_data = '0; m_err = 0;
            return;
        end
        have_w = 1'b0;
        w = '0;
        if (m_lsu.size() != 0)      begin w = m_lsu.pop_front(); have_w = 1'b1; end
        else if (m_alu.size() != 0) begin w = m_alu.pop_front(); have_w = 1'b1; end
        m_wr_en = have_w;
        if (have_w) begin m_wr_addr = w.rd; m_wr_data = w.data; end
        m_err = wb.alloc_en && wb.alloc_rd != 0 && m_pend[wb.alloc_rd];
        if (have_w) m_pend[w.rd] = 1'b0;
        if (wb.alloc_en && wb.alloc_rd != 0) m_pend[wb.alloc_rd] = 1'b1;
        if (wb.lsu_valid && rl && wb.lsu_rd != 0) m_lsu.push_back('{rd: wb.lsu_rd, data: wb.lsu_data});
        if (wb.alu_valid && ra && wb.alu_rd != 0) m_alu.push_back('{rd: wb.alu_rd, data: wb.alu_data});
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("alu_ready", 64'(wb.alu_ready), 64'(m_alu_rdy()));
            chk("lsu_ready", 64'(wb.lsu_ready), 64'(m_lsu_rdy()));
            chk("wr_en",     64'(wb.wr_en),     64'(m_wr_en));
            chk("wr_addr",   64'(wb.wr_addr),   64'(m_wr_addr));
            chk("wr_data",   64'(wb.wr_data),   64'(m_wr_data));
            chk("pending",   64'(wb.pending),   64'(m_pend));
            chk("alloc_err", 64'(wb.alloc_err), 64'(m_err));
        end
    end

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        wb.alu_valid = 0; wb.lsu_valid = 0; wb.alloc_en = 0;
    endtask

    task automatic put_alu(input int rd, input logic [XLEN-1:0] d);
        wb.alu_valid = 1; wb.alu_rd = AW'(rd); wb.alu_data = d;
    endtask

    task automatic put_lsu(input int rd, input logic [XLEN-1:0] d);
        wb.lsu_valid = 1; wb.lsu_rd = AW'(rd); wb.lsu_data = d;
    endtask

    task automatic alloc(input int rd);
        wb.alloc_en = 1; wb.alloc_rd = AW'(rd);
    endtask

    initial begin
        int pulses, first_c, last_c;
        int addrs[$];
        logic [XLEN-1:0] datas[$];
        wb.alu_rd = '0; wb.alu_data = '0; wb.lsu_rd = '0; wb.lsu_data = '0; wb.alloc_rd = '0;
        idle();

        // Reset state
        cyc(); cyc();
        chk_en = 1'b1;
        chk("rst_alu_ready", 64'(wb.alu_ready), 64'd0);
        chk("rst_lsu_ready", 64'(wb.lsu_ready), 64'd0);
        reset = 0;
        #1;
        chk("rst_wr_en", 64'(wb.wr_en), 64'd0);
        chk("rst_pending", 64'(wb.pending), 64'd0);
        chk("post_rst_alu_ready", 64'(wb.alu_ready), 64'd1);

        // Single ALU result with prior alloc
        alloc(5); cyc(); idle();
        chk("t1_pend5_set", 64'(wb.pending[5]), 64'd1);
        put_alu(5, 32'hDEADBEEF); cyc(); idle();
        chk("t1_t1_wr_en", 64'(wb.wr_en), 64'd0);
        cyc();
        chk("t1_wr_en", 64'(wb.wr_en), 64'd1);
        chk("t1_wr_addr", 64'(wb.wr_addr), 64'd5);
        chk("t1_wr_data", 64'(wb.wr_data), 64'hDEADBEEF);
        chk("t1_pend5_clr", 64'(wb.pending[5]), 64'd0);

        // Simultaneous sources: LSU first, ALU waits one cycle
        put_lsu(3, 32'h11111111); put_alu(4, 32'h22222222); cyc(); idle();
        chk("t2_alu_wait_ready", 64'(wb.alu_ready), 64'd0);
        pulses = 0;
        cyc();
        chk("t2_first_addr", 64'(wb.wr_addr), 64'd3);
        chk("t2_first_data", 64'(wb.wr_data), 64'h11111111);
        pulses += int'(wb.wr_en);
        cyc();
        chk("t2_second_addr", 64'(wb.wr_addr), 64'd4);
        chk("t2_second_data", 64'(wb.wr_data), 64'h22222222);
        pulses += int'(wb.wr_en);
        cyc(); pulses += int'(wb.wr_en);
        cyc(); pulses += int'(wb.wr_en);
        chk("t2_pulses", 64'(pulses), 64'd2);

        // x0 discard
        put_alu(0, 32'hFFFFFFFF);
        chk("t3_ready", 64'(wb.alu_ready), 64'd1);
        cyc(); idle();
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            pulses += int'(wb.wr_en);
        end
        chk("t3_no_write", 64'(pulses), 64'd0);
        chk("t3_pend0", 64'(wb.pending[0]), 64'd0);

        // Scoreboard race: alloc and commit to reg 7 on the same edge
        alloc(7); cyc(); idle();
        put_alu(7, 32'h00000077); cyc(); idle();
        alloc(7); cyc(); idle();
        chk("t4_wr_addr", 64'(wb.wr_addr), 64'd7);
        chk("t4_pend7", 64'(wb.pending[7]), 64'd1);
        chk("t4_err", 64'(wb.alloc_err), 64'd1);
        cyc();
        chk("t4_err_drop", 64'(wb.alloc_err), 64'd0);
        chk("t4_pend7_hold", 64'(wb.pending[7]), 64'd1);

        // Back-to-back ALU stream
        first_c = -1; last_c = -1;
        for (int i = 1; i <= 12; i++) begin
            if (i <= 8) begin
                put_alu(i, 32'h01010101 * i);
                chk("t5_ready", 64'(wb.alu_ready), 64'd1);
            end else idle();
            cyc();
            if (wb.wr_en) begin
                addrs.push_back(int'(wb.wr_addr));
                datas.push_back(wb.wr_data);
                if (first_c < 0) first_c = i;
                last_c = i;
            end
        end
        chk("t5_count", 64'(addrs.size()), 64'd8);
        chk("t5_contig", 64'(last_c - first_c), 64'd7);
        for (int k = 0; k < addrs.size(); k++) begin
            chk("t5_order", 64'(addrs[k]), 64'(k + 1));
            chk("t5_data", 64'(datas[k]), 64'(32'h01010101 * (k + 1)));
        end

        // Reset with both slots full
        put_lsu(9, 32'h99); put_alu(10, 32'hAA); alloc(12); cyc(); idle();
        chk("t6_pend12", 64'(wb.pending[12]), 64'd1);
        reset = 1; #1;
        chk("t6_alu_ready_rst", 64'(wb.alu_ready), 64'd0);
        chk("t6_lsu_ready_rst", 64'(wb.lsu_ready), 64'd0);
        cyc();
        chk("t6_wr_en", 64'(wb.wr_en), 64'd0);
        chk("t6_pending", 64'(wb.pending), 64'd0);
        reset = 0;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            pulses += int'(wb.wr_en);
        end
        chk("t6_no_write", 64'(pulses), 64'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            wb.alu_valid = ($urandom_range(0, 2) != 0);
            wb.alu_rd    = AW'($urandom_range(0, 7));
            wb.alu_data  = $urandom;
            wb.lsu_valid = ($urandom_range(0, 2) == 0);
            wb.lsu_rd    = AW'($urandom_range(0, 7));
            wb.lsu_data  = $urandom;
            wb.alloc_en  = ($urandom_range(0, 1) == 1);
            wb.alloc_rd  = AW'($urandom_range(0, 7));
            reset        = ($urandom_range(0, 199) == 0);
            cyc();
        end
        reset = 0; idle();
        cyc(); cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
